rr_arb_mux_4_1: RTL and testbench
=================================

# rr_arb_mux_4_1

Round-robin arbitrating 4:1 multiplexer with valid/ready handshakes on four 4-bit input lanes and one registered 4-bit output lane. It sits directly upstream of a combinational 4:1 mux selection stage. It generates the 2-bit select from a round-robin grant, routes the granted lane's data through `mux_4_1`, and presents the result through a one-entry output register. One word per cycle is sustained when the consumer is always ready.

## Interface
- `RESET_PTR`, default 0: lane index (0..3) holding highest priority after reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  4  per-lane request; bit i belongs to lane i.
- `in_data0`..`in_data3`  in  4 each  lane payloads.
- `in_ready`  out  4  per-lane accept, one-hot or zero; a word transfers on lane i when `in_valid[i] & in_ready[i]` at a rising edge.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts; transfer when `out_valid & out_ready`.
- `out_data`  out  4  registered payload.
- `out_sel`  out  2  registered index of the lane that supplied `out_data`.

## Operation
- State: `ptr` (2 bits, priority pointer), output register {`out_valid`, `out_data`, `out_sel`}.
- `load = !out_valid | out_ready`, meaning the output register is free or is being drained this cycle.
- Grant `g` is the first i with `in_valid[i]=1`, scanning `ptr, ptr+1, ptr+2, ptr+3` mod 4.
- `in_ready[g] = load & |in_valid`. All other `in_ready` bits are 0. `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `ptr`.
- On a clock edge with `load` and a grant:
  - `out_data <= mux_4_1(in_data0..3, sel=g)`
  - `out_sel <= g`
  - `out_valid <= 1`
  - `ptr <= g+1` (mod 4, wraps 3→0)
- On a clock edge with `load` and no request: `out_valid <= 0`. `out_data`, `out_sel` and `ptr` hold.
- On a clock edge with `!load` (stall): all state holds. `out_data` and `out_sel` must stay stable while `out_valid & !out_ready`.
- `ptr` advances only on an accepted input word, never on idle or stall cycles.
- Fairness: with all four lanes continuously valid and `out_ready=1`, grants rotate 0,1,2,3,0… (from `RESET_PTR`). Each lane waits at most 3 transfers.
- A lane dropping `in_valid` while not granted is legal and loses nothing. A lane keeps its data stable while `in_valid` is high and it is not yet accepted.

## Timing
- Reset (async assert, synchronous release at the `clk` edge): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=RESET_PTR`. `in_ready` is 0 while `rst_n=0`.
- Reset asserted mid-transfer discards the word held in the output register. No input is accepted while in reset.
- Latency: an input accepted at edge k appears on `out_data` and `out_valid` after edge k, available to the consumer in cycle k+1.
- Throughput: 1 word/cycle with `out_ready=1`. A simultaneous drain and load in the same cycle is required: no bubble.
- After a stall, the first cycle with `out_ready=1` both drains the held word and accepts the next granted word.

## Structure
- Shared package `rr_arb_pkg`:
  - `N_LANES=4`, `LANE_W=4`, `SEL_W=2`.
  - Typedef `lane_t` (`logic [3:0]`) and `sel_t` (`logic [1:0]`).
  - Function `rr_pick(valid, ptr)` returns the grant index plus a found flag.
- Sub-module `mux_4_1`, reused unchanged as the data-path select with `sel = g`.
- Arbitration logic, `ptr` and the output register stay in the top module.

## Test plan
- Reset: hold `rst_n=0` with `in_valid=4'b1111` → `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0`. Release → first grant goes to lane `RESET_PTR` (0).
- Rotation: all lanes valid with data a,b,c,d and `out_ready=1` for 8 cycles → `out_data` sequence a,b,c,d,a,b,c,d and `out_sel` 0,1,2,3,0,1,2,3, with no bubbles.
- Sparse requests: `in_valid=4'b1010`, `ptr=0` → grant lane 1, then lane 3, then lane 1. `ptr` wraps 3→0 correctly.
- Backpressure: after `out_data=b`/`out_sel=1` is loaded, hold `out_ready=0` for 3 cycles → `out_data` stays b, `in_ready=0`. Raise `out_ready` → next word c appears one cycle later.
- Idle: `in_valid=0` with `out_ready=1` → `out_valid` drops to 0 the cycle after the last transfer, `out_data` holds, and `ptr` is unchanged.
- Async reset mid-stall: assert `rst_n=0` between edges while `out_valid=1`, `out_ready=0` → `out_valid=0` immediately. After release, the first grant is lane `RESET_PTR`.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and round-robin pick helper for rr_arb_mux_4_1
package rr_arb_pkg;

   localparam int N_LANES = 4;
   localparam int LANE_W  = 4;
   localparam int SEL_W   = 2;

   typedef logic [LANE_W-1:0] lane_t;
   typedef logic [SEL_W-1:0]  sel_t;

   typedef struct packed {
      logic found;
      sel_t idx;
   } pick_t;

   // Scan from the far end back toward ptr so the closest requester wins last.
   function automatic pick_t rr_pick(input logic [N_LANES-1:0] valid, input sel_t ptr);
      pick_t r;
      sel_t  idx;
      r = '0;
      for (int k = N_LANES - 1; k >= 0; k--) begin
         idx = ptr + sel_t'(k);
         if (valid[idx]) begin
            r.found = 1'b1;
            r.idx   = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_4_1.sv
// rtl/mux_4_1.sv - combinational 4:1 selector for 4-bit lanes
module mux_4_1 (
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [1:0] sel,
   output logic [3:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd0: y = d0;
         2'd1: y = d1;
         2'd2: y = d2;
         2'd3: y = d3;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// rtl/rr_arb_mux_4_1.sv - round-robin 4:1 arbitrating mux with one-entry output register
module rr_arb_mux_4_1
   import rr_arb_pkg::*;
#(
   parameter int RESET_PTR = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_valid,
   input  logic [3:0] in_data0,
   input  logic [3:0] in_data1,
   input  logic [3:0] in_data2,
   input  logic [3:0] in_data3,
   output logic [3:0] in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic [1:0] out_sel
);

   localparam sel_t PTR_INIT = sel_t'(RESET_PTR);

   sel_t  ptr;
   pick_t pick;
   lane_t mux_y;
   logic  load;

   assign load = !out_valid || out_ready;
   assign pick = rr_pick(in_valid, ptr);

   always_comb begin
      in_ready = 4'b0000;
      if (rst_n && load && pick.found)
         in_ready = 4'b0001 << pick.idx;
   end

   mux_4_1 u_mux (
      .d0  (in_data0),
      .d1  (in_data1),
      .d2  (in_data2),
      .d3  (in_data3),
      .sel (pick.idx),
      .y   (mux_y)
   );

   // Drain and refill share one edge, so a ready consumer sees no bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= PTR_INIT;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (load) begin
         if (pick.found) begin
            out_valid <= 1'b1;
            out_data  <= mux_y;
            out_sel   <= pick.idx;
            ptr       <= pick.idx + sel_t'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// tb/tb_rr_arb_mux_4_1.sv - self-checking bench for rr_arb_mux_4_1
module tb_rr_arb_mux_4_1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] in_valid = 4'b0000;
   logic [3:0] din [4];
   logic [3:0] in_ready;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic [1:0] out_sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_arb_mux_4_1 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (din[0]),
      .in_data1  (din[1]),
      .in_data2  (din[2]),
      .in_data3  (din[3]),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   typedef struct {
      logic [3:0] valid;
      logic       ordy;
      logic [3:0] rdy;
      logic       ov;
      logic [3:0] data;
      logic [1:0] sel;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [3:0] v, input logic r, input logic [3:0] er,
                      input logic eov, input logic [3:0] ed, input logic [1:0] es);
      vec_t t;
      t.valid = v; t.ordy = r; t.rdy = er; t.ov = eov; t.data = ed; t.sel = es;
      tbl.push_back(t);
   endtask

   // Reference model: priority pointer and output slot as plain integers.
   int         m_ptr, m_ov, m_os;
   logic [3:0] m_od;

   function automatic int grant_of(input logic [3:0] v, input int p);
      for (int j = 0; j < 4; j++) begin
         if (v[(p + j) % 4]) return (p + j) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_ov = 0; m_os = 0; m_od = 4'h0;
   endtask

   task automatic rcycle();
      int         g;
      logic       ld;
      logic [3:0] er;
      ld = (m_ov == 0) || out_ready;
      g  = grant_of(in_valid, m_ptr);
      er = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
      #1;
      chk("rnd_in_ready", {28'b0, in_ready}, {28'b0, er});
      @(posedge clk);
      if (ld) begin
         if (g >= 0) begin
            m_od = din[g]; m_os = g; m_ov = 1; m_ptr = (g + 1) % 4;
         end else begin
            m_ov = 0;
         end
      end
      #1;
      chk("rnd_out_valid", {31'b0, out_valid}, m_ov);
      chk("rnd_out_data", {28'b0, out_data}, {28'b0, m_od});
      chk("rnd_out_sel", {30'b0, out_sel}, m_os);
   endtask

   initial begin
      din[0] = 4'hA; din[1] = 4'hB; din[2] = 4'hC; din[3] = 4'hD;

      // Rotation
      add(4'b1111, 1, 4'b0001, 1, 4'hA, 0);
      add(4'b1111, 1, 4'b0010, 1, 4'hB, 1);
      add(4'b1111, 1, 4'b0100, 1, 4'hC, 2);
      add(4'b1111, 1, 4'b1000, 1, 4'hD, 3);
      add(4'b1111, 1, 4'b0001, 1, 4'hA, 0);
      add(4'b1111, 1, 4'b0010, 1, 4'hB, 1);
      add(4'b1111, 1, 4'b0100, 1, 4'hC, 2);
      add(4'b1111, 1, 4'b1000, 1, 4'hD, 3);
      // Sparse, pointer wraps 3->0
      add(4'b1010, 1, 4'b0010, 1, 4'hB, 1);
      add(4'b1010, 1, 4'b1000, 1, 4'hD, 3);
      add(4'b1010, 1, 4'b0010, 1, 4'hB, 1);
      // Backpressure holds B
      add(4'b1111, 0, 4'b0000, 1, 4'hB, 1);
      add(4'b1111, 0, 4'b0000, 1, 4'hB, 1);
      add(4'b1111, 0, 4'b0000, 1, 4'hB, 1);
      add(4'b1111, 1, 4'b0100, 1, 4'hC, 2);
      // Idle: valid drops, data holds, ptr stays at 3
      add(4'b0000, 1, 4'b0000, 0, 4'hC, 2);
      add(4'b0000, 1, 4'b0000, 0, 4'hC, 2);
      // Empty register loads even with out_ready low
      add(4'b0100, 0, 4'b0100, 1, 4'hC, 2);
      add(4'b1111, 1, 4'b1000, 1, 4'hD, 3);
      add(4'b1111, 1, 4'b0001, 1, 4'hA, 0);

      // Reset held with all lanes requesting
      in_valid = 4'b1111; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_data", {28'b0, out_data}, 0);
      chk("rst_out_sel", {30'b0, out_sel}, 0);
      chk("rst_in_ready", {28'b0, in_ready}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         in_valid = tbl[i].valid;
         out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("tbl%0d_in_ready", i), {28'b0, in_ready}, {28'b0, tbl[i].rdy});
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
         chk($sformatf("tbl%0d_out_data", i), {28'b0, out_data}, {28'b0, tbl[i].data});
         chk($sformatf("tbl%0d_out_sel", i), {30'b0, out_sel}, {30'b0, tbl[i].sel});
      end

      // Async reset during a stall drops the held word at once
      in_valid = 4'b1111; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("stall_out_valid", {31'b0, out_valid}, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", {31'b0, out_valid}, 0);
      chk("async_rst_in_ready", {28'b0, in_ready}, 0);
      @(posedge clk); #1;
      chk("async_rst_hold_valid", {31'b0, out_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", {28'b0, in_ready}, 4'b0001);
      @(posedge clk); #1;
      chk("post_rst_out_sel", {30'b0, out_sel}, 0);
      chk("post_rst_out_data", {28'b0, out_data}, 4'hA);

      // Randomized run against the model
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 600; n++) begin
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int l = 0; l < 4; l++) din[l] = 4'($urandom);
         rcycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
